// File: rtl/pingpong_pkg.sv
// pingpong_pkg: shared types and constants for the ping-pong frame buffer
package pingpong_pkg;

    typedef enum logic [1:0] {
        R_IDLE,
        R_STREAM,
        R_DRAIN
    } rd_state_e;

    localparam int STATS_W = 16;

    // Skid entry layout. The data and tag widths depend on the top-level
    // parameters, so the packed struct itself is declared in the top level
    // with these same field names: data, channel, index, last.

endpackage

// File: rtl/pingpong_bank.sv
// pingpong_bank: single-port RAM, WORDS x WIDTH, registered read, contents never reset
// Ports: clk_i clock; we_i write enable; re_i read enable; addr_i shared address;
//        wdata_i write data; rdata_o read data one cycle after re_i
module pingpong_bank #(
    parameter int WIDTH = 24,
    parameter int WORDS = 8,
    parameter int AW    = 3
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        if (re_i) rdata_o <= mem_q[addr_i];
    end
endmodule

// File: rtl/pingpong_frame_buffer.sv
// pingpong_frame_buffer: two-bank frame buffer, interleaved write, channel-major streamed read
// Ports: clk_i/rst_ni clock and async active-low reset; sample_i/sample_valid_i input stream;
//        rd_data_o/rd_valid_o/rd_ready_i output handshake with rd_channel_o/rd_index_o/rd_last_o tags;
//        frame_ready_o/overrun_o one-cycle event pulses; frame_cnt_o/overrun_cnt_o saturating
//        statistics, present only with PINGPONG_FRAME_BUFFER_STATS_EN defined (else tied to 0)
module pingpong_frame_buffer
    import pingpong_pkg::*;
#(
    parameter  int WIDTH    = 24,
    parameter  int DEPTH    = 256,
    parameter  int CHANNELS = 1,
    localparam int CHW      = CHANNELS > 1 ? $clog2(CHANNELS) : 1,
    localparam int IW       = $clog2(DEPTH),
    localparam int AW       = $clog2(DEPTH * CHANNELS)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [WIDTH-1:0]   sample_i,
    input  logic               sample_valid_i,
    output logic [WIDTH-1:0]   rd_data_o,
    output logic               rd_valid_o,
    input  logic               rd_ready_i,
    output logic [CHW-1:0]     rd_channel_o,
    output logic [IW-1:0]      rd_index_o,
    output logic               rd_last_o,
    output logic               frame_ready_o,
    output logic               overrun_o,
    output logic [STATS_W-1:0] frame_cnt_o,
    output logic [STATS_W-1:0] overrun_cnt_o
);
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [CHW-1:0]   channel;
        logic [IW-1:0]    index;
        logic             last;
    } skid_t;

    rd_state_e        state_q, state_d;
    logic             wr_bank_q;
    logic [IW-1:0]    wr_t_q, rd_t_q, rd_t_d, pend_idx_q;
    logic [CHW-1:0]   wr_ch_q, rd_ch_q, rd_ch_d, pend_ch_q;
    logic             pend_q, frame_ready_q, overrun_q;
    skid_t            sk_q [2];
    logic             sk_rp_q, sk_wp_q;
    logic [1:0]       sk_cnt_q, occ, left;
    logic [WIDTH-1:0] rdata [2];
    logic [AW-1:0]    wr_addr, rd_addr;
    logic             frame_last, busy, swap, accept, push, pop, issue;
    skid_t            ram_e, out_e;

    assign wr_addr    = AW'(wr_t_q) * AW'(CHANNELS) + AW'(wr_ch_q);
    assign rd_addr    = AW'(rd_t_q) * AW'(CHANNELS) + AW'(rd_ch_q);
    assign frame_last = sample_valid_i && wr_t_q == IW'(DEPTH - 1) && wr_ch_q == CHW'(CHANNELS - 1);
    assign busy       = state_q != R_IDLE;
    assign swap       = frame_last && !busy;

    // The word read last cycle sits on the RAM output; it is presented directly
    // when the skid is empty and moved into the skid only if not taken now.
    always_comb begin
        ram_e      = '{data: rdata[~wr_bank_q], channel: pend_ch_q, index: pend_idx_q,
                       last: pend_idx_q == IW'(DEPTH - 1)};
        out_e      = sk_cnt_q != 2'd0 ? sk_q[sk_rp_q] : pend_q ? ram_e : '0;
        rd_valid_o = sk_cnt_q != 2'd0 || pend_q;
        accept     = rd_valid_o && rd_ready_i;
        push       = pend_q && !(sk_cnt_q == 2'd0 && rd_ready_i);
        pop        = sk_cnt_q != 2'd0 && rd_ready_i;
        occ        = sk_cnt_q + {1'b0, pend_q};
        left       = occ - {1'b0, accept};
        issue      = state_q == R_STREAM && left != 2'd2;
    end

    assign rd_data_o     = out_e.data;
    assign rd_channel_o  = out_e.channel;
    assign rd_index_o    = out_e.index;
    assign rd_last_o     = out_e.last;
    assign frame_ready_o = frame_ready_q;
    assign overrun_o     = overrun_q;

    always_comb begin
        state_d = state_q;
        rd_t_d  = rd_t_q;
        rd_ch_d = rd_ch_q;
        case (state_q)
            R_IDLE: if (swap) begin
                state_d = R_STREAM;
                rd_t_d  = '0;
                rd_ch_d = '0;
            end
            R_STREAM: if (issue) begin
                rd_t_d  = rd_t_q == IW'(DEPTH - 1) ? '0 : rd_t_q + 1'b1;
                if (rd_t_q == IW'(DEPTH - 1)) begin
                    rd_ch_d = rd_ch_q == CHW'(CHANNELS - 1) ? '0 : rd_ch_q + 1'b1;
                    if (rd_ch_q == CHW'(CHANNELS - 1)) state_d = R_DRAIN;
                end
            end
            R_DRAIN: if (left == 2'd0) state_d = R_IDLE;
            default: state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= R_IDLE;
            wr_bank_q     <= 1'b0;
            wr_t_q        <= '0;
            wr_ch_q       <= '0;
            rd_t_q        <= '0;
            rd_ch_q       <= '0;
            pend_q        <= 1'b0;
            pend_ch_q     <= '0;
            pend_idx_q    <= '0;
            frame_ready_q <= 1'b0;
            overrun_q     <= 1'b0;
            sk_q[0]       <= '0;
            sk_q[1]       <= '0;
            sk_rp_q       <= 1'b0;
            sk_wp_q       <= 1'b0;
            sk_cnt_q      <= '0;
        end else begin
            if (sample_valid_i) begin
                wr_ch_q <= wr_ch_q == CHW'(CHANNELS - 1) ? '0 : wr_ch_q + 1'b1;
                if (wr_ch_q == CHW'(CHANNELS - 1)) wr_t_q <= wr_t_q == IW'(DEPTH - 1) ? '0 : wr_t_q + 1'b1;
            end
            if (swap) wr_bank_q <= ~wr_bank_q;
            frame_ready_q <= swap;
            overrun_q     <= frame_last && busy;
            state_q       <= state_d;
            rd_t_q        <= rd_t_d;
            rd_ch_q       <= rd_ch_d;
            pend_q        <= issue;
            if (issue) begin
                pend_ch_q  <= rd_ch_q;
                pend_idx_q <= rd_t_q;
            end
            if (push) begin
                sk_q[sk_wp_q] <= ram_e;
                sk_wp_q       <= ~sk_wp_q;
            end
            if (pop) sk_rp_q <= ~sk_rp_q;
            sk_cnt_q <= sk_cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // The write bank takes the write address; the other bank is the read bank.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        pingpong_bank #(.WIDTH(WIDTH), .WORDS(DEPTH * CHANNELS), .AW(AW)) u_bank (
            .clk_i   (clk_i),
            .we_i    (sample_valid_i && wr_bank_q == 1'(b)),
            .re_i    (issue && wr_bank_q != 1'(b)),
            .addr_i  (wr_bank_q == 1'(b) ? wr_addr : rd_addr),
            .wdata_i (sample_i),
            .rdata_o (rdata[b])
        );
    end

`ifdef PINGPONG_FRAME_BUFFER_STATS_EN
    logic [STATS_W-1:0] frame_cnt_q, overrun_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_cnt_q   <= '0;
            overrun_cnt_q <= '0;
        end else begin
            if (frame_ready_q && frame_cnt_q != '1) frame_cnt_q <= frame_cnt_q + 1'b1;
            if (overrun_q && overrun_cnt_q != '1) overrun_cnt_q <= overrun_cnt_q + 1'b1;
        end
    end

    assign frame_cnt_o   = frame_cnt_q;
    assign overrun_cnt_o = overrun_cnt_q;
`else
    assign frame_cnt_o   = '0;
    assign overrun_cnt_o = '0;
`endif
endmodule

// File: tb/tb_pingpong_frame_buffer.sv
// tb_pingpong_frame_buffer: directed checks of the ping-pong frame buffer (4x2 and 2x1 configurations)
module tb_pingpong_frame_buffer;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [23:0] sample = '0, s_sample = '0;
    logic        sv = 1'b0, rdy = 1'b0, s_sv = 1'b0, s_rdy = 1'b1;
    logic [23:0] rd_data, s_rd_data;
    logic        rd_valid, rd_ch, rd_last, fr, ovr;
    logic        s_valid, s_ch, s_last, s_fr, s_ovr, s_idx;
    logic [1:0]  rd_idx;
    logic [15:0] fcnt, ocnt, s_fcnt, s_ocnt;
    int          checks = 0, errors = 0, fr_n = 0, ov_n = 0;
    logic [31:0] got_q[$], exp_q[$], s_got_q[$];
    logic        hold_p = 1'b0;
    logic [31:0] prev_w = '0, mon_w;
    logic [3:0]  pat = 4'b1001;

    always #5 clk = ~clk;

    pingpong_frame_buffer #(.WIDTH(24), .DEPTH(4), .CHANNELS(2)) d (
        .clk_i(clk), .rst_ni(rst_n), .sample_i(sample), .sample_valid_i(sv),
        .rd_data_o(rd_data), .rd_valid_o(rd_valid), .rd_ready_i(rdy),
        .rd_channel_o(rd_ch), .rd_index_o(rd_idx), .rd_last_o(rd_last),
        .frame_ready_o(fr), .overrun_o(ovr), .frame_cnt_o(fcnt), .overrun_cnt_o(ocnt));

    pingpong_frame_buffer #(.WIDTH(24), .DEPTH(2), .CHANNELS(1)) s (
        .clk_i(clk), .rst_ni(rst_n), .sample_i(s_sample), .sample_valid_i(s_sv),
        .rd_data_o(s_rd_data), .rd_valid_o(s_valid), .rd_ready_i(s_rdy),
        .rd_channel_o(s_ch), .rd_index_o(s_idx), .rd_last_o(s_last),
        .frame_ready_o(s_fr), .overrun_o(s_ovr), .frame_cnt_o(s_fcnt), .overrun_cnt_o(s_ocnt));

    function automatic logic [31:0] mk(logic [23:0] dv, logic c, logic [1:0] i, logic l);
        return {4'b0, l, i, c, dv};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [23:0] v);
        sample = v;
        sv = 1'b1;
        tick(1);
        sv = 1'b0;
    endtask

    task automatic ssend(input logic [23:0] v);
        s_sample = v;
        s_sv = 1'b1;
        tick(1);
        s_sv = 1'b0;
    endtask

    // Channel-major expected order of a 4x2 frame written as base+0..base+7.
    task automatic exp_frame(input logic [23:0] base);
        for (int i = 0; i < 8; i++) begin
            int t, c;
            t = i % 4;
            c = i / 4;
            exp_q.push_back(mk(base + 24'(t * 2 + c), 1'(c), 2'(t), t == 3));
        end
    endtask

    task automatic cmp_frames(input string tag);
        chk({tag, "_n"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk(tag, i < got_q.size() ? got_q[i] : 32'hFFFF_FFFF, exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        got_q.delete();
        exp_q.delete();
        s_got_q.delete();
        fr_n = 0;
        ov_n = 0;
    endtask

    always @(negedge clk) begin
        mon_w = mk(rd_data, rd_ch, rd_idx, rd_last);
        if (rst_n) begin
            if (hold_p) chk("hold", mon_w, prev_w);
            if (rd_valid && rdy) got_q.push_back(mon_w);
            if (s_valid && s_rdy) s_got_q.push_back(mk(s_rd_data, s_ch, {1'b0, s_idx}, s_last));
            if (fr) fr_n++;
            if (ovr) ov_n++;
        end
        hold_p = rst_n && rd_valid && !rdy;
        prev_w = mon_w;
    end

    initial begin
        tick(2);
        @(negedge clk);
        chk("rst_word", mk(rd_data, rd_ch, rd_idx, rd_last), 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_fr", fr, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_cnt", {fcnt, ocnt}, 0);
        chk("rst_bank", d.wr_bank_q, 0);
        do_reset();

        // single frame, full throughput
        rdy = 1'b1;
        for (int i = 0; i < 8; i++) send(24'h10 + 24'(i));
        @(negedge clk);
        chk("fr_pulse", fr, 1);
        chk("early_valid", rd_valid, 0);
        @(negedge clk);
        chk("first_valid", rd_valid, 1);
        chk("first_word", mk(rd_data, rd_ch, rd_idx, rd_last), mk(24'h10, 0, 0, 0));
        repeat (7) @(negedge clk);
        chk("last_valid", rd_valid, 1);
        chk("last_word", mk(rd_data, rd_ch, rd_idx, rd_last), mk(24'h17, 1, 3, 1));
        @(negedge clk);
        chk("after_valid", rd_valid, 0);
        tick(1);
        exp_frame(24'h10);
        cmp_frames("single");
        chk("single_bank", d.wr_bank_q, 1);
        chk("single_frn", fr_n, 1);

        // backpressure 1,0,0,1
        do_reset();
        fork
            for (int i = 0; i < 8; i++) send(24'h20 + 24'(i));
            for (int j = 0; j < 64; j++) begin
                rdy = pat[j % 4];
                @(posedge clk);
                #1;
            end
        join
        rdy = 1'b1;
        tick(4);
        exp_frame(24'h20);
        cmp_frames("bp");

        // continuous stream, one sample every 8 cycles
        do_reset();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 8; i++) begin
                send(24'(f + 1) * 24'h100 + 24'(i));
                tick(7);
            end
            exp_frame(24'(f + 1) * 24'h100);
            chk("cont_bank", d.wr_bank_q, f % 2 == 0);
        end
        tick(4);
        cmp_frames("cont");
        chk("cont_ovn", ov_n, 0);
        chk("cont_frn", fr_n, 3);

        // overrun
        do_reset();
        rdy = 1'b0;
        for (int i = 0; i < 8; i++) send(24'h40 + 24'(i));
        for (int i = 0; i < 8; i++) send(24'h50 + 24'(i));
        @(negedge clk);
        chk("ovr_pulse", ovr, 1);
        chk("ovr_nofr", fr, 0);
        @(negedge clk);
        chk("ovr_once", ovr, 0);
        tick(1);
        rdy = 1'b1;
        tick(12);
        exp_frame(24'h40);
        cmp_frames("ovr_f1");
        for (int i = 0; i < 8; i++) send(24'h60 + 24'(i));
        tick(12);
        exp_frame(24'h60);
        cmp_frames("ovr_f3");
        chk("ovr_ovn", ov_n, 1);
        chk("ovr_frn", fr_n, 2);
`ifdef PINGPONG_FRAME_BUFFER_STATS_EN
        chk("stat_frames", fcnt, 2);
        chk("stat_overruns", ocnt, 1);
`else
        chk("stat_frames", fcnt, 0);
        chk("stat_overruns", ocnt, 0);
`endif

        // asynchronous reset mid-frame while output is valid
        do_reset();
        rdy = 1'b0;
        for (int i = 0; i < 8; i++) send(24'h70 + 24'(i));
        for (int i = 0; i < 5; i++) send(24'h78 + 24'(i));
        tick(2);
        chk("pre_rst_valid", rd_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", rd_valid, 0);
        chk("arst_word", mk(rd_data, rd_ch, rd_idx, rd_last), 0);
        chk("arst_bank", d.wr_bank_q, 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        got_q.delete();
        rdy = 1'b1;
        for (int i = 0; i < 8; i++) send(24'h80 + 24'(i));
        tick(12);
        exp_frame(24'h80);
        cmp_frames("rst");

        // CHANNELS=1, DEPTH=2
        ssend(24'hA);
        ssend(24'hB);
        @(negedge clk);
        chk("s_fr", s_fr, 1);
        tick(5);
        chk("s_n", s_got_q.size(), 2);
        if (s_got_q.size() == 2) begin
            chk("s_w0", s_got_q[0], mk(24'hA, 0, 0, 0));
            chk("s_w1", s_got_q[1], mk(24'hB, 0, 1, 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
